// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit mux among 8 requesters, with a per-grant hold limit.
// Optional MUX8_LOCK_EN adds a lock input that suppresses hold-limit rotation.
module mux8_rr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MUX8_LOCK_EN
    input  logic             lock,
`endif
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] I,
    output logic [N_REQ-1:0] gnt,
    output logic             S0,
    output logic             S1,
    output logic             S2,
    output logic             busy,
    output logic             Out,
    output logic             out_valid
);

    // state   | meaning
    // ST_IDLE | no grant active, gnt/sel zero
    // ST_BUSY | one requester owns the mux
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
    logic [3:0]       r_hold, w_hold_nxt;
    logic             r_out, r_valid;
    logic [N_REQ-1:0] w_others;
    logic [SEL_W-1:0] w_sel_p1;
    logic [SEL_W-1:0] w_win;
    logic             w_lock;

    // First set bit of v searching upward from start, wrapping modulo N_REQ.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                                 input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] w_best;
        logic [SEL_W-1:0] w_idx;
        w_best = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = start + SEL_W'(k);
            if (v[w_idx]) w_best = w_idx;
        end
        return w_best;
    endfunction

`ifdef MUX8_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_out   <= (r_state == ST_BUSY) ? I[r_sel] : 1'b0;
            r_valid <= (r_state == ST_BUSY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_others    = req & ~(N_REQ'(1) << r_sel);
        w_sel_p1    = r_sel + SEL_W'(1);
        w_win       = '0;

        case (r_state)
            ST_IDLE: begin
                if (req != '0) begin
                    w_win       = rr_pick(req, r_ptr);
                    w_state_nxt = ST_BUSY;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_sel_nxt   = w_win;
                    w_hold_nxt  = 4'd1;
                end
            end
            ST_BUSY: begin
                if (!req[r_sel]) begin
                    w_ptr_nxt = w_sel_p1;
                    if (w_others != '0) begin
                        w_win      = rr_pick(w_others, w_sel_p1);
                        w_gnt_nxt  = N_REQ'(1) << w_win;
                        w_sel_nxt  = w_win;
                        w_hold_nxt = 4'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_sel_nxt   = '0;
                        w_hold_nxt  = '0;
                    end
                end else if ((r_hold == HOLD_MAX) && (w_others != '0) && !w_lock) begin
                    w_win      = rr_pick(w_others, w_sel_p1);
                    w_ptr_nxt  = w_sel_p1;
                    w_gnt_nxt  = N_REQ'(1) << w_win;
                    w_sel_nxt  = w_win;
                    w_hold_nxt = 4'd1;
                end else begin
                    w_hold_nxt = (r_hold == HOLD_MAX) ? r_hold : r_hold + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_sel_nxt   = '0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign S0        = r_sel[0];
    assign S1        = r_sel[1];
    assign S2        = r_sel[2];
    assign busy      = (r_state == ST_BUSY);
    assign Out       = r_out;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural round-robin model.
module tb_mux8_rr_arbiter;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] I;
    logic [7:0] gnt;
    logic       S0, S1, S2, busy, Out, out_valid;
`ifdef MUX8_LOCK_EN
    logic       lock;
`endif

    always #5 clk = ~clk;

    mux8_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX8_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .I         (I),
        .gnt       (gnt),
        .S0        (S0),
        .S1        (S1),
        .S2        (S2),
        .busy      (busy),
        .Out       (Out),
        .out_valid (out_valid)
    );

    int errors = 0;
    int checks = 0;

    // Model: granted index (-1 = idle), priority pointer, cycles held, registered data.
    int   m_idx  = -1;
    int   m_ptr  = 0;
    int   m_held = 0;
    logic m_out  = 1'b0;
    logic m_valid = 1'b0;

    function automatic int search(logic [7:0] v, int from);
        for (int k = 0; k < 8; k++)
            if (v[(from + k) % 8]) return (from + k) % 8;
        return -1;
    endfunction

    function automatic logic cur_lock();
`ifdef MUX8_LOCK_EN
        return lock;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [7:0] others;
        if (rst) begin
            m_idx = -1; m_ptr = 0; m_held = 0; m_out = 1'b0; m_valid = 1'b0;
        end else begin
            m_out   = (m_idx >= 0) ? I[m_idx] : 1'b0;
            m_valid = (m_idx >= 0);
            if (m_idx < 0) begin
                if (req != 8'h00) begin
                    m_idx  = search(req, m_ptr);
                    m_held = 1;
                end
            end else begin
                others = req;
                others[m_idx] = 1'b0;
                if (!req[m_idx]) begin
                    m_ptr = (m_idx + 1) % 8;
                    m_idx = search(others, m_ptr);
                    m_held = (m_idx >= 0) ? 1 : 0;
                end else if (others != 8'h00 && m_held >= MAX_HOLD && !cur_lock()) begin
                    m_ptr  = (m_idx + 1) % 8;
                    m_idx  = search(others, m_ptr);
                    m_held = 1;
                end else begin
                    m_held++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] eg;
        eg = (m_idx >= 0) ? (8'h01 << m_idx) : 8'h00;
        check("gnt", gnt, eg);
        check("busy", {7'b0, busy}, {7'b0, (m_idx >= 0)});
        if (m_idx >= 0) check("sel", {5'b0, S2, S1, S0}, 8'(m_idx));
        check("Out", {7'b0, Out}, {7'b0, m_out});
        check("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] exp_g;
        rst = 1'b1; req = 8'hFF; I = 8'h00;
`ifdef MUX8_LOCK_EN
        lock = 1'b0;
`endif
        #2;
        // Reset with all requests pending
        step(); step();
        check("rst gnt", gnt, 8'h00);
        check("rst sel", {5'b0, S2, S1, S0}, 8'h00);
        check("rst busy", {7'b0, busy}, 8'h00);
        check("rst Out", {7'b0, Out}, 8'h00);
        check("rst valid", {7'b0, out_valid}, 8'h00);
        rst = 1'b0;
        step();
        check("first gnt", gnt, 8'h01);

        // Full contention: index advances every MAX_HOLD cycles, never idles
        for (int j = 1; j <= 32; j++) begin
            step();
            exp_g = 8'h01 << ((j / 4) % 8);
            check("contention gnt", gnt, exp_g);
        end

        // Single request from idle
        rst = 1'b1; step(); rst = 1'b0; req = 8'h00; step();
        req = 8'h20; I = 8'h20;
        step();
        check("single gnt", gnt, 8'h20);
        check("single sel", {5'b0, S2, S1, S0}, 8'h05);
        check("single busy", {7'b0, busy}, 8'h01);
        step();
        check("single Out", {7'b0, Out}, 8'h01);
        check("single valid", {7'b0, out_valid}, 8'h01);
        req = 8'h00;
        step();
        check("drop gnt", gnt, 8'h00);
        check("drop last valid", {7'b0, out_valid}, 8'h01);
        step();
        check("drop valid", {7'b0, out_valid}, 8'h00);

        // Hand-off from index 2 to 6 without idle bubble
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h04; step();
        check("hand gnt2", gnt, 8'h04);
        req = 8'h44; step();
        check("hand keep", gnt, 8'h04);
        req = 8'h40; step();
        check("hand gnt6", gnt, 8'h40);
        check("hand sel", {5'b0, S2, S1, S0}, 8'h06);
        check("hand busy", {7'b0, busy}, 8'h01);

        // Uncontended hold on requester 7
        req = 8'h80;
        for (int k = 0; k < 10; k++) begin
            I = 8'($urandom);
            step();
            check("uncont gnt", gnt, 8'h80);
            if (k > 0) check("uncont Out", {7'b0, Out}, {7'b0, I[7]});
        end

        // Reset mid-grant clears pointer
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h08; step();
        check("mid gnt3", gnt, 8'h08);
        rst = 1'b1; step();
        check("mid rst gnt", gnt, 8'h00);
        rst = 1'b0; req = 8'h09; step();
        check("ptr reset gnt", gnt, 8'h01);

`ifdef MUX8_LOCK_EN
        lock = 1'b1; req = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            step();
            check("lock gnt", gnt, 8'h01);
        end
        lock = 1'b0;
`endif

        // Randomized traffic with sticky requests and occasional reset
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 40) == 0) req = 8'h00;
            if ($urandom_range(0, 40) == 0) req = 8'hFF;
            I   = 8'($urandom);
            rst = ($urandom_range(0, 150) == 0);
`ifdef MUX8_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
